esm_regmap_pipe: RTL and testbench

Parametrised register-index remapping stage for the instruction stream.
- Rewrites the rd, rs1 and rs2 fields of each instruction through a programmable permutation table of regnum entries.
- Sits between fetch and decode, with a valid/ready handshake on both sides.
- The table is reprogrammed at run time by atomic swap commands, so it is always a permutation with x0 fixed.

---
 rtl/esm_regmap_pipe.sv | 176 +++++++++++++++++
 tb/tb_esm_regmap_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/esm_regmap_pipe.sv
// esm_regmap_pipe
//   Register-index remapping stage between fetch and decode. The rd, rs1 and
//   rs2 fields of each instruction are rewritten through a programmable
//   permutation table. The table is changed only by atomic swap commands, so
//   it always remains a permutation with x0 fixed. The output is registered,
//   giving one cycle of latency and full throughput under a valid/ready
//   handshake.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   Instr_in, RegWrite, ALUSrc       incoming instruction and sidebands
//   in_valid / in_ready              upstream handshake
//   Instr_out, RegWrite_out,
//   ALUSrc_out                       registered remapped instruction
//   out_valid / out_ready            downstream handshake
//   cfg_valid, cfg_a, cfg_b          swap command: exchange table[a] and table[b]
//   cfg_err                          one-cycle pulse for a rejected swap
//   stat_instr, stat_remap           saturating statistics counters
//
// Build option
//   ESM_STATS_EN  when defined, stat_instr counts accepted instructions and
//                 stat_remap counts accepted instructions with at least one
//                 changed field. When undefined, both outputs are tied to 0.
module esm_regmap_pipe #(
  parameter int unsigned Instruction_word_size = 32,
  parameter int unsigned regnum                = 16,
  parameter int unsigned IDX_W                 = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [Instruction_word_size-1:0] Instr_in,
  input  logic                             RegWrite,
  input  logic                             ALUSrc,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [Instruction_word_size-1:0] Instr_out,
  output logic                             RegWrite_out,
  output logic                             ALUSrc_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             cfg_valid,
  input  logic [IDX_W-1:0]                 cfg_a,
  input  logic [IDX_W-1:0]                 cfg_b,
  output logic                             cfg_err,
  output logic [31:0]                      stat_instr,
  output logic [31:0]                      stat_remap
);

  typedef logic [IDX_W-1:0] tbl_t [regnum];

  // Index 0 and indices >= regnum map to themselves. The compare-select loop
  // avoids indexing the table with an out-of-range field value.
  function automatic logic [IDX_W-1:0] lookup(input tbl_t tbl,
                                              input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] res;
    res = idx;
    for (int unsigned i = 1; i < regnum; i++) begin
      if (idx == IDX_W'(i)) res = tbl[i];
    end
    return res;
  endfunction

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return (idx != '0) && (32'(idx) < regnum);
  endfunction

  tbl_t                             table_q, table_d;
  logic [Instruction_word_size-1:0] instr_q, instr_d;
  logic                             regwrite_q, regwrite_d;
  logic                             alusrc_q, alusrc_d;
  logic                             valid_q, valid_d;
  logic                             cfg_err_q, cfg_err_d;

  logic                             accept;
  logic                             swap_ok;
  logic [IDX_W-1:0]                 val_a, val_b;
  logic [Instruction_word_size-1:0] remapped;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign swap_ok  = cfg_valid && idx_ok(cfg_a) && idx_ok(cfg_b);

  // Rewrite uses the current (pre-swap) table.
  always_comb begin
    remapped = Instr_in;
    remapped[19:15] = lookup(table_q, Instr_in[19:15]);
    if (RegWrite) remapped[11:7]  = lookup(table_q, Instr_in[11:7]);
    if (!ALUSrc)  remapped[24:20] = lookup(table_q, Instr_in[24:20]);
  end

  // Both entries are read before either is written, so the exchange is
  // atomic; a == b writes the same value back and is a natural no-op.
  always_comb begin
    table_d = table_q;
    val_a   = lookup(table_q, cfg_a);
    val_b   = lookup(table_q, cfg_b);
    if (swap_ok) begin
      for (int unsigned i = 1; i < regnum; i++) begin
        if (cfg_a == IDX_W'(i))      table_d[i] = val_b;
        else if (cfg_b == IDX_W'(i)) table_d[i] = val_a;
      end
    end
  end

  always_comb begin
    instr_d    = instr_q;
    regwrite_d = regwrite_q;
    alusrc_d   = alusrc_q;
    valid_d    = valid_q;
    if (accept) begin
      instr_d    = remapped;
      regwrite_d = RegWrite;
      alusrc_d   = ALUSrc;
      valid_d    = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    cfg_err_d = cfg_valid && !swap_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < regnum; i++) table_q[i] <= IDX_W'(i);
      instr_q    <= '0;
      regwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      valid_q    <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      table_q    <= table_d;
      instr_q    <= instr_d;
      regwrite_q <= regwrite_d;
      alusrc_q   <= alusrc_d;
      valid_q    <= valid_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign Instr_out    = instr_q;
  assign RegWrite_out = regwrite_q;
  assign ALUSrc_out   = alusrc_q;
  assign out_valid    = valid_q;
  assign cfg_err      = cfg_err_q;

`ifdef ESM_STATS_EN
  logic [31:0] stat_instr_q, stat_instr_d;
  logic [31:0] stat_remap_q, stat_remap_d;

  always_comb begin
    stat_instr_d = stat_instr_q;
    stat_remap_d = stat_remap_q;
    if (accept) begin
      if (stat_instr_q != '1) stat_instr_d = stat_instr_q + 32'd1;
      if ((remapped != Instr_in) && (stat_remap_q != '1))
        stat_remap_d = stat_remap_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_instr_q <= '0;
      stat_remap_q <= '0;
    end else begin
      stat_instr_q <= stat_instr_d;
      stat_remap_q <= stat_remap_d;
    end
  end

  assign stat_instr = stat_instr_q;
  assign stat_remap = stat_remap_q;
`else
  assign stat_instr = '0;
  assign stat_remap = '0;
`endif

endmodule

// File: tb/tb_esm_regmap_pipe.sv
module tb_esm_regmap_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instr_in;
  logic        RegWrite, ALUSrc, in_valid, in_ready;
  logic [31:0] Instr_out;
  logic        RegWrite_out, ALUSrc_out, out_valid, out_ready;
  logic        cfg_valid;
  logic [4:0]  cfg_a, cfg_b;
  logic        cfg_err;
  logic [31:0] stat_instr, stat_remap;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] W_ADD   = 32'h00C58533; // add x10, x11, x12
  localparam logic [31:0] W_ADD_S = 32'h00A58633; // after swap(10,12)
  localparam logic [31:0] W_RD5   = 32'h00C582B3; // rd=5, rs1=11, rs2=12
  localparam logic [31:0] W1      = 32'h002081B3; // rd=3, rs1=1, rs2=2
  localparam logic [31:0] W2      = 32'h00418233; // rd=4, rs1=3, rs2=4

  esm_regmap_pipe #(
    .Instruction_word_size(32),
    .regnum(16),
    .IDX_W(5)
  ) dut (
    .clk(clk), .rst(rst),
    .Instr_in(Instr_in), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .in_valid(in_valid), .in_ready(in_ready),
    .Instr_out(Instr_out), .RegWrite_out(RegWrite_out), .ALUSrc_out(ALUSrc_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .cfg_valid(cfg_valid), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_err(cfg_err),
    .stat_instr(stat_instr), .stat_remap(stat_remap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic rw, input logic as);
    Instr_in = w;
    RegWrite = rw;
    ALUSrc   = as;
    in_valid = 1'b1;
  endtask

  task automatic swap(input logic [4:0] a, input logic [4:0] b);
    cfg_valid = 1'b1;
    cfg_a     = a;
    cfg_b     = b;
  endtask

  initial begin
    rst = 1'b1; Instr_in = '0; RegWrite = 1'b0; ALUSrc = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; cfg_valid = 1'b0; cfg_a = '0; cfg_b = '0;
    tick(); tick();
    rst = 1'b0;

    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_instr_out", Instr_out, 32'h0);
    check_eq("rst_regwrite",  32'(RegWrite_out), 32'd0);
    check_eq("rst_alusrc",    32'(ALUSrc_out), 32'd0);
    check_eq("rst_cfg_err",   32'(cfg_err), 32'd0);
    check_eq("rst_in_ready",  32'(in_ready), 32'd1);
    check_eq("rst_stat_instr", stat_instr, 32'd0);
    check_eq("rst_stat_remap", stat_remap, 32'd0);

    // Identity passthrough
    send(W_ADD, 1'b1, 1'b0);
    tick();
    check_eq("ident_instr", Instr_out, W_ADD);
    check_eq("ident_valid", 32'(out_valid), 32'd1);
    check_eq("ident_rw",    32'(RegWrite_out), 32'd1);
    check_eq("ident_as",    32'(ALUSrc_out), 32'd0);
    in_valid = 1'b0;
    tick();
    check_eq("drain_valid", 32'(out_valid), 32'd0);

    // Swap(10,12) with an instruction accepted in the same cycle
    swap(5'd10, 5'd12);
    send(W_ADD, 1'b1, 1'b0);
    tick();
    check_eq("swap_cycle_instr", Instr_out, W_ADD);
    check_eq("swap_ok_err", 32'(cfg_err), 32'd0);
    cfg_valid = 1'b0;
    tick();
    check_eq("post_swap_rtype", Instr_out, W_ADD_S);

    // I-type: rs2 slot is immediate and must stay
    send(32'h00450613, 1'b1, 1'b1);
    tick();
    check_eq("itype_rw1", Instr_out, 32'h00460513);
    check_eq("itype_as_out", 32'(ALUSrc_out), 32'd1);
    send(32'h00450613, 1'b0, 1'b1);
    tick();
    check_eq("itype_rw0", Instr_out, 32'h00460613);
    check_eq("itype_rw_out", 32'(RegWrite_out), 32'd0);

    // rs1 = 20 is beyond regnum and passes; rd=10 remaps
    send(32'h000A0533, 1'b1, 1'b0);
    tick();
    check_eq("field_ge_regnum", Instr_out, 32'h000A0633);
    in_valid = 1'b0;

    // Illegal swap with index 0
    swap(5'd0, 5'd5);
    tick();
    check_eq("err_zero_idx", 32'(cfg_err), 32'd1);
    cfg_valid = 1'b0;
    tick();
    check_eq("err_one_cycle", 32'(cfg_err), 32'd0);
    send(W_RD5, 1'b1, 1'b0);
    tick();
    check_eq("err_table_kept", Instr_out, 32'h00A582B3);
    in_valid = 1'b0;

    // Illegal swap with index == regnum
    swap(5'd3, 5'd16);
    tick();
    check_eq("err_ge_regnum", 32'(cfg_err), 32'd1);

    // Same-index swap is a silent no-op
    swap(5'd7, 5'd7);
    tick();
    check_eq("same_idx_no_err", 32'(cfg_err), 32'd0);
    cfg_valid = 1'b0;
    send(32'h00C583B3, 1'b1, 1'b0);
    tick();
    check_eq("same_idx_table", Instr_out, 32'h00A583B3);
    in_valid = 1'b0;

    // Highest legal index
    swap(5'd5, 5'd15);
    tick();
    check_eq("swap_top_err", 32'(cfg_err), 32'd0);
    cfg_valid = 1'b0;
    send(W_RD5, 1'b1, 1'b0);
    tick();
    check_eq("swap_top_map", Instr_out, 32'h00A587B3);
    in_valid = 1'b0;
    tick();

    // Backpressure
    out_ready = 1'b0;
    send(W1, 1'b1, 1'b0);
    tick();
    check_eq("bp_first_instr", Instr_out, W1);
    check_eq("bp_first_valid", 32'(out_valid), 32'd1);
    Instr_in = W2;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      check_eq("bp_hold_instr", Instr_out, W1);
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check_eq("bp_next_instr", Instr_out, W2);
    check_eq("bp_next_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    check_eq("bp_drained", 32'(out_valid), 32'd0);

    // Reset mid-operation with a held output and a swapped table
    out_ready = 1'b0;
    send(W_ADD, 1'b1, 1'b0);
    tick();
    check_eq("pre_rst_instr", Instr_out, W_ADD_S);
    rst = 1'b1;
    swap(5'd1, 5'd2);
    tick();
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_instr", Instr_out, 32'h0);
    check_eq("mid_rst_err",   32'(cfg_err), 32'd0);
    check_eq("mid_rst_stat_i", stat_instr, 32'd0);
    check_eq("mid_rst_stat_r", stat_remap, 32'd0);
    rst = 1'b0;
    cfg_valid = 1'b0;
    out_ready = 1'b1;
    send(W_ADD, 1'b1, 1'b0);
    tick();
    check_eq("post_rst_ident", Instr_out, W_ADD);
    send(W1, 1'b1, 1'b0);
    tick();
    check_eq("post_rst_noswap", Instr_out, W1);
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
